operand_issue_fifo: RTL and testbench
=====================================

OPERAND_ISSUE_FIFO -- requirements
Module: operand_issue_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of operand-pair entries; power of two, at least 2.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  producer offers an operand pair.
REQ-006 The block SHALL have port in_a  input  WIDTH  operand A offered.
REQ-007 The block SHALL have port in_b  input  WIDTH  operand B offered.
REQ-008 The block SHALL have port in_ready  output  1  FIFO can accept a pair this cycle.
REQ-009 The block SHALL have port flush  input  1  synchronous discard of all stored pairs.
REQ-010 The block SHALL have port out_valid  output  1  head pair is presented to the downstream adder/accumulator.
REQ-011 The block SHALL have port out_a  output  WIDTH  head operand A, drives adder A.
REQ-012 The block SHALL have port out_b  output  WIDTH  head operand B, drives adder B.
REQ-013 The block SHALL have port out_ready  input  1  downstream consumes the head pair this cycle.
REQ-014 The block SHALL have port count  output  $clog2(DEPTH+1)  number of stored pairs.

Function
REQ-015 The block SHALL perform a push when in_valid and in_ready are both 1 at a rising edge, storing {in_a, in_b} at the tail.
REQ-016 The block SHALL perform a pop when out_valid and out_ready are both 1 at a rising edge, removing the head pair.
REQ-017 The block SHALL drive in_ready = (count < DEPTH), registered-state based, with no combinational path from out_ready.
REQ-018 When full, the block SHALL reject a push even if a pop occurs in the same cycle.
REQ-019 The block SHALL drive out_valid = (count != 0).
REQ-020 The block SHALL drive out_a/out_b from the head entry in show-ahead mode; a push into an empty FIFO appears on the outputs the next cycle, giving 1-cycle latency.
REQ-021 The block SHALL hold out_a/out_b stable while out_valid=1 and out_ready=0.
REQ-022 On a simultaneous push and pop with 0 < count < DEPTH, the block SHALL leave count unchanged and advance both pointers.
REQ-023 When count=0, the block SHALL ignore out_ready; no pop occurs and count does not underflow.
REQ-024 The block SHALL wrap read and write pointers modulo DEPTH.
REQ-025 When flush=1, the block SHALL set count, the read pointer and the write pointer to 0 at the next edge; any push or pop in that cycle is discarded, and flush has priority over both.
REQ-026 When count=0, the block SHALL drive out_a/out_b to 0 regardless of storage contents.

Reset
REQ-027 When reset=0, the block SHALL asynchronously clear the pointers and count; outputs then read out_valid=0, in_ready=1, count=0, out_a=0, out_b=0.
REQ-028 The block SHALL not require clearing of storage contents on reset; REQ-026 masks them.
REQ-029 On reset asserted mid-transfer, the block SHALL lose all stored pairs; it accepts pushes from the first rising edge after reset returns to 1.

Structure
REQ-030 The default WIDTH and DEPTH constants SHALL reside in the shared adder_pkg package, used by both the adder/accumulator stage and this block.
REQ-031 The storage array SHALL be the sub-module opfifo_mem, with DEPTH x 2*WIDTH entries, write port and asynchronous read port; control logic stays in operand_issue_fifo.

Verification
REQ-032 The bench SHALL cover reset: hold reset=0 for 2 cycles, then release -> count=0, out_valid=0, in_ready=1, out_a=out_b=0.
REQ-033 The bench SHALL cover single pair and latency: push (1,2) with out_ready=0 -> next cycle out_valid=1, out_a=1, out_b=2, count=1; then out_ready=1 for 1 cycle -> count=0.
REQ-034 The bench SHALL cover fill and backpressure: push (1,2),(4,5),(3,1),(7,1) -> count=4, in_ready=0; offering (15,1) with out_ready=1 in the same cycle -> pop only, count=3, (15,1) not stored.
REQ-035 The bench SHALL cover order and wrap: push 6 pairs interleaved with pops -> the popped sequence equals the push order exactly across the pointer wrap.
REQ-036 The bench SHALL cover simultaneous push and pop: at count=2, push (2,2) with pop -> count stays 2 and the head advances to the next older pair.
REQ-037 The bench SHALL cover flush and mid-operation reset: at count=3, flush=1 with in_valid=1 -> count=0 and nothing stored; refill to 2, then reset=0 asynchronously between edges -> count=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/adder_pkg.sv
// Constants shared by the adder/accumulator stage and its operand issue FIFO.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH = 4;
    localparam int unsigned ADDER_DEPTH = 4;

endpackage : adder_pkg

// File: rtl/opfifo_mem.sv
// Operand-pair storage: one synchronous write port and one asynchronous read port.
// Contents are not reset; the controller masks stale data when the FIFO is empty.
module opfifo_mem #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write the tail entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read of the head entry.
    assign rdata = mem[raddr];

endmodule : opfifo_mem

// File: rtl/operand_issue_fifo.sv
// Show-ahead FIFO of operand pairs feeding the adder/accumulator stage.
// Handshake flags derive only from the stored count, so there is no
// combinational path from out_ready to in_ready.
module operand_issue_fifo
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH,
    parameter int unsigned DEPTH = ADDER_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_a,
    output logic [WIDTH-1:0]           out_b,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned DW = 2 * WIDTH;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;
    logic [DW-1:0] head;

    assign count     = cnt;
    assign in_ready  = (cnt < CW'(DEPTH));
    assign out_valid = (cnt != '0);

    // Accepted transfers; flush discards both sides of the handshake.
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        if (!flush) begin
            push = in_valid && in_ready;
            pop  = out_valid && out_ready;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PW'(wr_ptr + PW'(1));
            end
            if (pop) begin
                rd_ptr <= PW'(rd_ptr + PW'(1));
            end
            case ({push, pop})
                2'b10:   cnt <= CW'(cnt + CW'(1));
                2'b01:   cnt <= CW'(cnt - CW'(1));
                default: cnt <= cnt;
            endcase
        end
    end

    opfifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_a, in_b}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head operands, forced to zero while empty so stale storage never leaks.
    always_comb begin
        out_a = '0;
        out_b = '0;
        if (out_valid) begin
            out_a = head[DW-1:WIDTH];
            out_b = head[WIDTH-1:0];
        end
    end

endmodule : operand_issue_fifo

// File: tb/tb_operand_issue_fifo.sv
// Directed bench for operand_issue_fifo with a queue-based reference model.
module tb_operand_issue_fifo;
    import adder_pkg::*;

    localparam int unsigned W  = ADDER_WIDTH;
    localparam int unsigned D  = ADDER_DEPTH;
    localparam int unsigned CW = $clog2(D + 1);

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic          out_ready;
    logic [CW-1:0] count;

    int n_cmp;
    int n_err;

    pair_t mq[$];
    pair_t popped[$];
    pair_t exp_seq[6];

    operand_issue_fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of pairs with capacity D.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            automatic bit do_push = in_valid && (mq.size() < D);
            automatic bit do_pop  = out_ready && (mq.size() != 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{a: in_a, b: in_b});
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int a, input int b, input bit rdy, input bit fl);
        in_valid  = v;
        in_a      = W'(a);
        in_b      = W'(b);
        out_ready = rdy;
        flush     = fl;
    endtask

    // Advance one clock and compare every output against the model.
    task automatic cycle();
        int sz;
        @(posedge clk);
        #2;
        sz = mq.size();
        check("model_count", int'(count), sz);
        check("model_out_valid", int'(out_valid), (sz != 0) ? 1 : 0);
        check("model_in_ready", int'(in_ready), (sz < D) ? 1 : 0);
        check("model_out_a", int'(out_a), (sz != 0) ? int'(mq[0].a) : 0);
        check("model_out_b", int'(out_b), (sz != 0) ? int'(mq[0].b) : 0);
    endtask

    task automatic push_pair(input int a, input int b);
        drive(1'b1, a, b, 1'b0, 1'b0);
        cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0);

        // Reset held for two cycles, then released.
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("reset_count", int'(count), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_a", int'(out_a), 0);
        check("reset_out_b", int'(out_b), 0);

        // Single pair, one-cycle latency, then consumed.
        push_pair(1, 2);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        check("single_out_valid", int'(out_valid), 1);
        check("single_out_a", int'(out_a), 1);
        check("single_out_b", int'(out_b), 2);
        check("single_count", int'(count), 1);
        cycle();
        check("single_hold_a", int'(out_a), 1);
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        cycle();
        check("single_pop_count", int'(count), 0);

        // Fill and backpressure: full FIFO rejects a push even with a pop.
        push_pair(1, 2);
        push_pair(4, 5);
        push_pair(3, 1);
        push_pair(7, 1);
        check("full_count", int'(count), 4);
        check("full_in_ready", int'(in_ready), 0);
        drive(1'b1, 15, 1, 1'b1, 1'b0);
        cycle();
        check("bp_count", int'(count), 3);
        check("bp_head_a", int'(out_a), 4);
        check("bp_head_b", int'(out_b), 5);
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        cycle();
        cycle();
        check("bp_last_a", int'(out_a), 7);
        check("bp_last_b", int'(out_b), 1);
        cycle();
        check("bp_drained", int'(count), 0);
        cycle();
        check("underflow_count", int'(count), 0);

        // Order across pointer wrap: push six pairs while popping.
        exp_seq[0] = '{a: 4'd1,  b: 4'd1};
        exp_seq[1] = '{a: 4'd2,  b: 4'd3};
        exp_seq[2] = '{a: 4'd4,  b: 4'd5};
        exp_seq[3] = '{a: 4'd6,  b: 4'd7};
        exp_seq[4] = '{a: 4'd8,  b: 4'd9};
        exp_seq[5] = '{a: 4'd10, b: 4'd11};
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(1'b1, int'(exp_seq[i].a), int'(exp_seq[i].b), 1'b1, 1'b0);
            else       drive(1'b0, 0, 0, 1'b1, 1'b0);
            if (out_valid && out_ready) popped.push_back('{a: out_a, b: out_b});
            cycle();
        end
        check("wrap_pop_len", popped.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < popped.size()) begin
                check("wrap_order_a", int'(popped[i].a), int'(exp_seq[i].a));
                check("wrap_order_b", int'(popped[i].b), int'(exp_seq[i].b));
            end
        end

        // Simultaneous push and pop at count 2.
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        push_pair(9, 8);
        push_pair(5, 6);
        check("sim_pre_count", int'(count), 2);
        drive(1'b1, 2, 2, 1'b1, 1'b0);
        cycle();
        check("sim_count", int'(count), 2);
        check("sim_head_a", int'(out_a), 5);
        check("sim_head_b", int'(out_b), 6);

        // Flush beats a concurrent push.
        push_pair(3, 3);
        check("flush_pre_count", int'(count), 3);
        drive(1'b1, 12, 12, 1'b0, 1'b1);
        cycle();
        check("flush_count", int'(count), 0);
        check("flush_out_valid", int'(out_valid), 0);
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        cycle();
        check("flush_empty_a", int'(out_a), 0);

        // Refill, then asynchronous reset between edges.
        push_pair(1, 1);
        push_pair(2, 2);
        check("refill_count", int'(count), 2);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("async_count", int'(count), 0);
        check("async_out_valid", int'(out_valid), 0);
        check("async_in_ready", int'(in_ready), 1);
        cycle();
        reset = 1'b1;
        push_pair(7, 7);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        check("post_reset_count", int'(count), 1);
        check("post_reset_a", int'(out_a), 7);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_operand_issue_fifo
